// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and data_memory.
// Aligned accesses pass straight through; misaligned halfword/word accesses become byte-serial beats.
module load_store_unit #(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter int unsigned ADDR_W           = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic              mem_unsigned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            r_state, w_next;
  logic              r_write, r_unsigned, r_split, r_err;
  logic [1:0]        r_size, r_beat, r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_rdata;

  logic              w_misaligned, w_reject;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_load;

  assign w_misaligned = (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign w_reject     = (req_size == 2'b11) || (w_misaligned && !ALLOW_MISALIGNED);
  assign w_wbyte      = r_wdata[{r_beat, 3'b000} +: 8];

  // Aligned loads arrive already extended by data_memory; only split halves need extending here.
  assign w_load = (r_split && r_size == 2'b01) ?
                  {{16{!r_unsigned && r_rdata[15]}}, r_rdata[15:0]} : r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_split    <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= '0;
      r_beat     <= '0;
      r_last     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_unsigned <= req_unsigned;
            r_size     <= req_size;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
            r_beat     <= '0;
            r_split    <= w_misaligned;
            r_err      <= w_reject;
            r_last     <= !w_misaligned ? 2'd0 : (req_size == 2'b01 ? 2'd1 : 2'd3);
          end
        end
        S_ACCESS: begin
          r_beat <= r_beat + 2'd1;
          if (!r_write) begin
            if (r_split) r_rdata[{r_beat, 3'b000} +: 8] <= mem_rdata[7:0];
            else         r_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next       = r_state;
    busy         = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_size     = '0;
    mem_unsigned = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = w_reject ? S_DONE : S_ACCESS;
      end
      S_ACCESS: begin
        busy      = 1'b1;
        mem_read  = !r_write;
        mem_write = r_write;
        if (r_split) begin
          mem_size     = 2'b00;
          mem_unsigned = 1'b1;
          mem_addr     = r_addr + ADDR_W'(r_beat);
          mem_wdata    = {24'h0, w_wbyte};
        end else begin
          mem_size     = r_size;
          mem_unsigned = r_unsigned;
          mem_addr     = r_addr;
          mem_wdata    = r_wdata;
        end
        if (r_beat == r_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        resp_err   = r_err;
        if (!r_err && !r_write) resp_rdata = w_load;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data_memory model plus a byte-level reference of each access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, resp_valid, resp_err, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        req_valid_na, busy_na, resp_valid_na, resp_err_na;
  logic        mem_read_na, mem_write_na, mem_unsigned_na;
  logic [1:0]  mem_size_na;
  logic [31:0] resp_rdata_na, mem_addr_na, mem_wdata_na;
  logic [31:0] na_rdata = 32'h1234_5678;

  load_store_unit #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  load_store_unit #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut_na (
    .clk(clk), .rst(rst), .req_valid(req_valid_na), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy_na),
    .resp_valid(resp_valid_na), .resp_rdata(resp_rdata_na), .resp_err(resp_err_na),
    .mem_read(mem_read_na), .mem_write(mem_write_na), .mem_size(mem_size_na),
    .mem_unsigned(mem_unsigned_na), .mem_addr(mem_addr_na), .mem_wdata(mem_wdata_na),
    .mem_rdata(na_rdata));

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t        acc_q[$];
  acc_t        a_mon;
  logic [7:0]  mem     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] m_v;
  int unsigned m_nb;
  int unsigned n_tests = 0, n_fail = 0;

  function automatic logic [7:0] dflt(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // data_memory stand-in: write and combinational-style read resolved mid-cycle
  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      a_mon.wr = mem_write; a_mon.rd = mem_read; a_mon.size = mem_size;
      a_mon.uns = mem_unsigned; a_mon.addr = mem_addr; a_mon.wdata = mem_wdata;
      acc_q.push_back(a_mon);
    end
    m_nb = (mem_size == 2'b11) ? 4 : (1 << mem_size);
    if (mem_write)
      for (int unsigned k = 0; k < m_nb; k++) mem[mem_addr + k] = mem_wdata[8*k +: 8];
    m_v = '0;
    if (mem_read) begin
      for (int unsigned k = 0; k < m_nb; k++) m_v[8*k +: 8] = mem_rd(mem_addr + k);
      if (!mem_unsigned && m_nb == 1) m_v = {{24{m_v[7]}}, m_v[7:0]};
      if (!mem_unsigned && m_nb == 2) m_v = {{16{m_v[15]}}, m_v[15:0]};
    end
    mem_rdata = m_v;
  end

  task automatic do_req(string tag, bit wr, logic [1:0] sz, bit uns, logic [31:0] addr,
                        logic [31:0] wd, bit poke, output logic [31:0] rd);
    int unsigned nb, n_exp, lat_exp, cyc, extra;
    bit          mis, err_exp, got;
    logic [31:0] exp_rd;
    logic        e;
    acc_t        a;
    nb      = (sz == 2'b11) ? 1 : (1 << sz);
    err_exp = (sz == 2'b11);
    mis     = !err_exp && (addr % nb) != 0;
    n_exp   = err_exp ? 0 : (mis ? nb : 1);
    lat_exp = err_exp ? 1 : n_exp + 1;
    exp_rd  = '0;
    if (!err_exp) begin
      if (wr) for (int unsigned k = 0; k < nb; k++) ref_mem[addr + k] = wd[8*k +: 8];
      else begin
        for (int unsigned k = 0; k < nb; k++) exp_rd[8*k +: 8] = ref_rd(addr + k);
        if (!uns && nb == 1) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
        if (!uns && nb == 2) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
      end
    end
    acc_q.delete();
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = poke;
    if (poke) req_addr = addr ^ 32'h40;
    cyc = 0; got = 0; rd = '0; e = 1'b0;
    while (!got && cyc < 16) begin
      cyc++;
      @(negedge clk);
      if (resp_valid) begin got = 1; rd = resp_rdata; e = resp_err; end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    check({tag, "/latency"}, got ? cyc : 0, lat_exp);
    check({tag, "/err"}, e, err_exp);
    check({tag, "/rdata"}, rd, exp_rd);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) extra++;
    end
    check({tag, "/busy_after"}, busy, 0);
    check({tag, "/extra_resp"}, extra, 0);
    @(posedge clk); #1;
    check({tag, "/n_access"}, acc_q.size(), n_exp);
    for (int unsigned i = 0; i < n_exp && i < acc_q.size(); i++) begin
      a = acc_q[i];
      check({tag, "/addr"}, a.addr, mis ? addr + i : addr);
      check({tag, "/size"}, a.size, mis ? 2'b00 : sz);
      check({tag, "/dir"}, {a.wr, a.rd}, {wr, !wr});
      check({tag, "/uns"}, a.uns, mis ? 1'b1 : uns);
      if (wr) check({tag, "/wdata"}, a.wdata, mis ? {24'h0, wd[8*i +: 8]} : wd);
    end
  endtask

  logic [31:0] r, old403, raddr;
  logic [1:0]  rsz;
  int unsigned stray;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid_na = 1'b0; req_write = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", busy, 0);
    check("reset/resp_valid", resp_valid, 0);
    check("reset/mem_rw", {mem_read, mem_write}, 0);
    check("reset/mem_addr", mem_addr, 0);
    check("reset/resp_rdata", resp_rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req("sw100", 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, r);
    do_req("lw100", 0, 2'b10, 0, 32'h100, 32'h0, 1, r);
    check("lw100/value", r, 32'hDEADBEEF);
    do_req("sw201", 1, 2'b10, 0, 32'h201, 32'h11223344, 0, r);
    do_req("lw201", 0, 2'b10, 0, 32'h201, 32'h0, 0, r);
    check("lw201/value", r, 32'h11223344);
    do_req("sh303", 1, 2'b01, 0, 32'h303, 32'h000080F0, 0, r);
    do_req("lh303", 0, 2'b01, 0, 32'h303, 32'h0, 1, r);
    check("lh303/value", r, 32'hFFFF80F0);
    do_req("lhu303", 0, 2'b01, 1, 32'h303, 32'h0, 0, r);
    check("lhu303/value", r, 32'h000080F0);
    do_req("illegal", 0, 2'b11, 0, 32'h100, 32'h0, 0, r);
    do_req("lw_wrap", 0, 2'b10, 0, 32'hFFFFFFFE, 32'h0, 0, r);

    for (int i = 0; i < 40; i++) begin
      rsz   = 2'($urandom_range(0, 3));
      raddr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3)
                                          : 32'h1000 + $urandom_range(0, 15);
      do_req("rand", 1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), raddr,
             $urandom, $urandom_range(0, 3) == 0, r);
    end

    // Abort a split store after its second byte: written bytes stay, no response follows.
    old403 = mem_rd(32'h403);
    acc_q.delete();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h401; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_mid/busy", busy, 0);
    check("rst_mid/mem_rw", {mem_read, mem_write}, 0);
    check("rst_mid/mem_addr", mem_addr, 0);
    check("rst_mid/mem_wdata", mem_wdata, 0);
    stray = resp_valid ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    check("rst_mid/no_resp", stray, 0);
    check("rst_mid/n_access", acc_q.size(), 2);
    check("rst_mid/b401", mem_rd(32'h401), 8'hDD);
    check("rst_mid/b402", mem_rd(32'h402), 8'hCC);
    check("rst_mid/b403", mem_rd(32'h403), old403);
    ref_mem[32'h401] = 8'hDD; ref_mem[32'h402] = 8'hCC;
    @(posedge clk); #1;
    do_req("lb402", 0, 2'b00, 1, 32'h402, 32'h0, 0, r);
    check("lb402/value", r, 32'h000000CC);

    // Instance without misaligned support
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h2;
    req_valid_na = 1'b1;
    @(posedge clk); #1; req_valid_na = 1'b0;
    @(negedge clk);
    check("na_lw2/resp_valid", resp_valid_na, 1);
    check("na_lw2/err", resp_err_na, 1);
    check("na_lw2/rdata", resp_rdata_na, 0);
    check("na_lw2/mem_rw", {mem_read_na, mem_write_na}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("na_lw2/idle", busy_na, 0);
    @(posedge clk); #1;
    req_addr = 32'h4; req_valid_na = 1'b1;
    @(posedge clk); #1; req_valid_na = 1'b0;
    @(negedge clk);
    check("na_lw4/mem_read", mem_read_na, 1);
    check("na_lw4/mem_addr", mem_addr_na, 32'h4);
    check("na_lw4/early_resp", resp_valid_na, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("na_lw4/resp_valid", resp_valid_na, 1);
    check("na_lw4/err", resp_err_na, 0);
    check("na_lw4/rdata", resp_rdata_na, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequencer between the core's execute stage and data_memory; drives every data_memory port.
- Aligned byte/half/word accesses pass through as one memory access.
- Misaligned halfword/word accesses are split into byte-serial accesses. Load bytes are reassembled and sign/zero-extended; store bytes are written low-address first.
- Asserts busy so the core stalls until the response is returned.

Parameters:
ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into bytes; 0 = return resp_err with no memory access
ADDR_W, 32, address width; beat addresses wrap modulo 2^ADDR_W

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  access request; sampled only in IDLE
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  1 = zero-extend load result
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, little-endian
busy  output  1  high whenever state != IDLE
resp_valid  output  1  one-cycle pulse: access complete
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid; illegal size, or misaligned with ALLOW_MISALIGNED=0
mem_read  output  1  to data_memory.mem_read
mem_write  output  1  to data_memory.mem_write
mem_size  output  2  to data_memory.mem_size
mem_unsigned  output  1  to data_memory.unsigned_load
mem_addr  output  ADDR_W  to data_memory.data_addr
mem_wdata  output  32  to data_memory.data_write_data
mem_rdata  input  32  from data_memory.data_read_data; combinational from mem_addr while mem_read=1

Behaviour:
- Clocking/reset: one clock, clk; rst is synchronous and active-high.
- Reset values: state IDLE; busy, resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata, mem_addr, mem_wdata, mem_size, mem_unsigned = 0.
- States: IDLE -> ACCESS -> DONE -> IDLE. Illegal or rejected requests go IDLE -> DONE.
- IDLE:
  - On a rising edge with req_valid=1, latch all req_* fields and clear the beat counter.
  - Misaligned = (size 01 and addr[0]) or (size 10 and addr[1:0] != 0).
  - Beat count N = 1 if aligned; 2 for misaligned half; 4 for misaligned word.
  - Next state is DONE with err=1 if size = 11, or if misaligned with ALLOW_MISALIGNED=0. Otherwise next state is ACCESS.
- ACCESS, aligned (N=1):
  - mem_size = latched size; mem_unsigned = latched unsigned; mem_addr = addr; mem_wdata = wdata.
  - Loads latch mem_rdata unchanged; data_memory performs the extension.
- ACCESS, misaligned, beat i (0..N-1):
  - mem_size = 00; mem_unsigned = 1; mem_addr = addr + i (wraps).
  - Stores: mem_wdata[7:0] = wdata[8i+7:8i].
  - Loads: at the edge, latch mem_rdata[7:0] into assembled byte i.
- ACCESS, all cases:
  - mem_read = !write; mem_write = write; exactly one of the two is high per ACCESS cycle.
  - The counter advances each cycle; move to DONE after beat N-1.
- Memory outputs outside ACCESS: mem_read = mem_write = 0; address and data driven 0.
- DONE:
  - resp_valid = 1 for exactly one cycle; resp_err as decided in IDLE.
  - Misaligned loads: resp_rdata = assembled value, sign-extended from bit 15 (half) when req_unsigned=0, else zero-extended. Word loads take the assembled 32 bits with no extension.
  - Returns to IDLE. A new request is accepted no earlier than the edge ending the DONE cycle.
- Latency, counted from the acceptance edge: resp_valid is high in cycle N+1; error responses are high in cycle 1.
- req_valid while busy=1 is ignored, not queued. The core holds req_valid until it observes resp_valid.
- Reset mid-operation: return to IDLE at the next edge. Store beats already written stay in memory (no rollback); no resp_valid is produced for the aborted request.
- Address wrap: misaligned word at 0xFFFFFFFE touches bytes FE, FF, 00, 01.

Test Plan:
- Aligned: sw 0xDEADBEEF @0x100, then lw @0x100 -> 1 mem_write cycle with mem_size=10; resp_rdata = 0xDEADBEEF, resp_valid 2 cycles after each acceptance.
- Misaligned store: sw 0x11223344 @0x201 -> 4 byte writes to 0x201..0x204 with data 44, 33, 22, 11. Then lw @0x201 -> 0x11223344, resp_valid in cycle 5.
- Misaligned half: sh 0x80F0 @0x303, then lh @0x303 -> 0xFFFF80F0; lhu @0x303 -> 0x000080F0.
- Illegal and rejected requests:
  - req_size = 11 -> no mem_read/mem_write; resp_valid + resp_err in cycle 1; resp_rdata = 0.
  - ALLOW_MISALIGNED=0 with lw @0x2 -> same error response.
- Reset mid-operation: assert rst after beat 1 of sw 0xAABBCCDD @0x401 -> next cycle all outputs 0, busy = 0; bytes 0x401 = DD and 0x402 = CC stay written; 0x403 is unchanged.
- Ignored request and wrap: req_valid pulses while busy are ignored (one response only). Misaligned lw @0xFFFFFFFE issues addresses FE, FF, 00, 01.
